// File: rtl/secuenciador_ciclo_lavadora_pkg.sv
// secuenciador_pkg: state codes and program codes shared by the washer sequencer and its bench
// Ports: none (package).
package secuenciador_pkg;
  typedef logic [3:0] fase_t;
  localparam fase_t ST_IDLE          = 4'd0;
  localparam fase_t ST_ESPERA_PUERTA = 4'd1;
  localparam fase_t ST_LLENADO       = 4'd2;
  localparam fase_t ST_LAVADO        = 4'd3;
  localparam fase_t ST_ENJUAGUE      = 4'd4;
  localparam fase_t ST_CENTRIFUGADO  = 4'd5;
  localparam fase_t ST_SECADO        = 4'd6;
  localparam fase_t ST_FIN           = 4'd7;
  localparam fase_t ST_ERROR         = 4'd8;
  typedef enum logic [1:0] {NONE, SEC, LAV, PES} prog_t;
endpackage

// File: rtl/secuenciador_ciclo_lavadora_if.sv
// secuenciador_ciclo_lavadora_if: program requests, sensors and actuator/status lines of the washer sequencer
// Ports: none; master drives requests and sensors, slave (the sequencer) drives actuators and status.
interface secuenciador_ciclo_lavadora_if;
  logic SECADO, LAVADO, LAVADO_PESADO, INSUFICIENTE, PUERTA_CERRADA, NIVEL_AGUA_OK;
  logic VALVULA_AGUA, MOTOR_LAVADO, MOTOR_CENTRIF, CALENTADOR, BLOQUEO_PUERTA;
  logic OCUPADO, FIN_CICLO, ERROR;
  logic [3:0] FASE;
  modport master (
    output SECADO, LAVADO, LAVADO_PESADO, INSUFICIENTE, PUERTA_CERRADA, NIVEL_AGUA_OK,
    input  VALVULA_AGUA, MOTOR_LAVADO, MOTOR_CENTRIF, CALENTADOR, BLOQUEO_PUERTA,
           OCUPADO, FIN_CICLO, ERROR, FASE
  );
  modport slave (
    input  SECADO, LAVADO, LAVADO_PESADO, INSUFICIENTE, PUERTA_CERRADA, NIVEL_AGUA_OK,
    output VALVULA_AGUA, MOTOR_LAVADO, MOTOR_CENTRIF, CALENTADOR, BLOQUEO_PUERTA,
           OCUPADO, FIN_CICLO, ERROR, FASE
  );
endinterface

// File: rtl/secuenciador_ciclo_lavadora_temporizador.sv
// lavadora_temporizador: loadable down-counter that saturates at zero and flags zero
// Ports: clk, rst (sync, active high), load_i/val_i load the count, zero_o is high while the count is 0.
module lavadora_temporizador #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
  end
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/secuenciador_ciclo_lavadora.sv
// secuenciador_ciclo_lavadora: sequences the washer phases for a granted program
// Ports: clk, RESET (sync, active high), bus (slave modport: requests/sensors in, actuators/status out).
module secuenciador_ciclo_lavadora
  import secuenciador_pkg::*;
#(
  parameter int CNT_W           = 8,
  parameter int T_LLENADO_MAX   = 40,
  parameter int T_LAVADO        = 20,
  parameter int T_LAVADO_PESADO = 40,
  parameter int T_ENJUAGUE      = 10,
  parameter int T_CENTRIFUGADO  = 10,
  parameter int T_SECADO        = 15
) (
  input logic                          clk,
  input logic                          RESET,
  secuenciador_ciclo_lavadora_if.slave bus
);
  fase_t state_q, state_d;
  prog_t prog_q, prog_d;
  logic t_load, t_zero, locked;
  logic [CNT_W-1:0] t_val;
  assign locked = state_q inside {ST_LLENADO, ST_LAVADO, ST_ENJUAGUE, ST_CENTRIFUGADO, ST_SECADO};
  lavadora_temporizador #(.CNT_W(CNT_W)) u_tmr (
    .clk(clk), .rst(RESET), .load_i(t_load), .val_i(t_val), .zero_o(t_zero)
  );
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      prog_q <= NONE;
    end else begin
      state_q <= state_d;
      prog_q <= prog_d;
    end
  end
  always_comb begin
    state_d = state_q;
    prog_d = prog_q;
    case (state_q)
      ST_IDLE: if (!bus.INSUFICIENTE && (bus.LAVADO_PESADO || bus.LAVADO || bus.SECADO)) begin
        state_d = ST_ESPERA_PUERTA;
        prog_d = bus.LAVADO_PESADO ? PES : bus.LAVADO ? LAV : SEC;
      end
      ST_ESPERA_PUERTA: if (bus.PUERTA_CERRADA) state_d = (prog_q == SEC) ? ST_SECADO : ST_LLENADO;
      ST_LLENADO:       state_d = bus.NIVEL_AGUA_OK ? ST_LAVADO : t_zero ? ST_ERROR : ST_LLENADO;
      ST_LAVADO:        if (t_zero) state_d = ST_ENJUAGUE;
      ST_ENJUAGUE:      if (t_zero) state_d = ST_CENTRIFUGADO;
      ST_CENTRIFUGADO:  if (t_zero) state_d = (prog_q == PES) ? ST_SECADO : ST_FIN;
      ST_SECADO:        if (t_zero) state_d = ST_FIN;
      ST_FIN:           state_d = ST_IDLE;
      ST_ERROR:         state_d = ST_ERROR;
      default:          state_d = ST_IDLE;
    endcase
    // an opened door while locked beats every other exit, including timer expiry
    if (locked && !bus.PUERTA_CERRADA) state_d = ST_ERROR;
    // every phase change reloads the timer with the duration of the phase being entered
    t_load = state_d != state_q;
    t_val = CNT_W'(state_d == ST_LLENADO ? T_LLENADO_MAX - 1 :
                   state_d == ST_LAVADO ? (prog_q == PES ? T_LAVADO_PESADO : T_LAVADO) - 1 :
                   state_d == ST_ENJUAGUE ? T_ENJUAGUE - 1 :
                   state_d == ST_CENTRIFUGADO ? T_CENTRIFUGADO - 1 : T_SECADO - 1);
  end
  always_comb begin
    bus.FASE = state_q;
    bus.VALVULA_AGUA = state_q inside {ST_LLENADO, ST_ENJUAGUE};
    bus.MOTOR_LAVADO = state_q inside {ST_LAVADO, ST_ENJUAGUE, ST_SECADO};
    bus.MOTOR_CENTRIF = state_q == ST_CENTRIFUGADO;
    bus.CALENTADOR = state_q == ST_SECADO || (state_q == ST_LAVADO && prog_q == PES);
    bus.BLOQUEO_PUERTA = locked;
    bus.OCUPADO = state_q != ST_IDLE;
    bus.FIN_CICLO = state_q == ST_FIN;
    bus.ERROR = state_q == ST_ERROR;
  end
endmodule

// File: tb/tb_secuenciador_ciclo_lavadora.sv
// tb_secuenciador_ciclo_lavadora: self-checking bench for the washer sequencer
module tb_secuenciador_ciclo_lavadora;
  import secuenciador_pkg::*;
  localparam int TLM = 6, TL = 5, TLP = 8, TE = 3, TC = 3, TS = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  secuenciador_ciclo_lavadora_if bus();
  secuenciador_ciclo_lavadora #(
    .CNT_W(8), .T_LLENADO_MAX(TLM), .T_LAVADO(TL), .T_LAVADO_PESADO(TLP),
    .T_ENJUAGUE(TE), .T_CENTRIFUGADO(TC), .T_SECADO(TS)
  ) dut (.clk(clk), .RESET(rst), .bus(bus));
  logic [7:0] dut_o;
  assign dut_o = {bus.VALVULA_AGUA, bus.MOTOR_LAVADO, bus.MOTOR_CENTRIF, bus.CALENTADOR,
                  bus.BLOQUEO_PUERTA, bus.OCUPADO, bus.FIN_CICLO, bus.ERROR};
  int n_tests = 0, n_fail = 0;
  fase_t m_fase = ST_IDLE;
  prog_t m_prog = NONE;
  int m_fill = 0;
  fase_t plan[$];
  int hist[16];
  int fin_cnt, cal_cnt;
  typedef struct {
    logic r, s, l, p, i, d, n;
    logic [3:0] fase;
    logic [7:0] outs;
  } vec_t;
  vec_t tbl[19];
  // expected actuator/status bits {valve, wash, spin, heater, lock, busy, end, error} per phase
  function automatic logic [7:0] exp_out(fase_t f, prog_t p);
    case (f)
      ST_ESPERA_PUERTA: return 8'b0000_0100;
      ST_LLENADO:       return 8'b1000_1100;
      ST_LAVADO:        return (p == PES) ? 8'b0101_1100 : 8'b0100_1100;
      ST_ENJUAGUE:      return 8'b1100_1100;
      ST_CENTRIFUGADO:  return 8'b0010_1100;
      ST_SECADO:        return 8'b0101_1100;
      ST_FIN:           return 8'b0000_0110;
      ST_ERROR:         return 8'b0000_0101;
      default:          return 8'b0000_0000;
    endcase
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic r, s, l, p, i, d, n);
    rst = r;
    bus.SECADO = s;
    bus.LAVADO = l;
    bus.LAVADO_PESADO = p;
    bus.INSUFICIENTE = i;
    bus.PUERTA_CERRADA = d;
    bus.NIVEL_AGUA_OK = n;
  endtask
  // reference: on acceptance the whole post-fill schedule is laid out as one phase code per cycle
  task automatic model_edge();
    if (rst) begin
      m_fase = ST_IDLE;
      m_prog = NONE;
      plan.delete();
    end else if (m_fase inside {ST_LLENADO, ST_LAVADO, ST_ENJUAGUE, ST_CENTRIFUGADO, ST_SECADO} && !bus.PUERTA_CERRADA)
      m_fase = ST_ERROR;
    else case (m_fase)
      ST_IDLE: if (!bus.INSUFICIENTE && (bus.SECADO || bus.LAVADO || bus.LAVADO_PESADO)) begin
        m_prog = bus.LAVADO_PESADO ? PES : bus.LAVADO ? LAV : SEC;
        plan.delete();
        if (m_prog != SEC) begin
          repeat (m_prog == PES ? TLP : TL) plan.push_back(ST_LAVADO);
          repeat (TE) plan.push_back(ST_ENJUAGUE);
          repeat (TC) plan.push_back(ST_CENTRIFUGADO);
        end
        if (m_prog != LAV) repeat (TS) plan.push_back(ST_SECADO);
        plan.push_back(ST_FIN);
        m_fase = ST_ESPERA_PUERTA;
      end
      ST_ESPERA_PUERTA: if (bus.PUERTA_CERRADA) begin
        if (m_prog == SEC) m_fase = plan.pop_front();
        else begin
          m_fase = ST_LLENADO;
          m_fill = 1;
        end
      end
      ST_LLENADO: begin
        if (bus.NIVEL_AGUA_OK) m_fase = plan.pop_front();
        else if (m_fill == TLM) m_fase = ST_ERROR;
        else m_fill++;
      end
      ST_FIN:   m_fase = ST_IDLE;
      ST_ERROR: m_fase = ST_ERROR;
      default:  m_fase = plan.pop_front();
    endcase
  endtask
  task automatic step(input string nm);
    model_edge();
    @(posedge clk);
    #1;
    hist[bus.FASE]++;
    if (bus.FIN_CICLO) fin_cnt++;
    if (bus.CALENTADOR) cal_cnt++;
    chk({nm, " fase/outs"}, {20'd0, bus.FASE, dut_o}, {20'd0, m_fase, exp_out(m_fase, m_prog)});
  endtask
  task automatic clear_hist();
    foreach (hist[k]) hist[k] = 0;
    fin_cnt = 0;
    cal_cnt = 0;
  endtask
  task automatic run_until(input fase_t target, input int max, input string nm);
    int k = 0;
    while (bus.FASE != target && k < max) begin
      step(nm);
      k++;
    end
    chk({nm, " reached"}, {28'd0, bus.FASE}, {28'd0, target});
  endtask
  task automatic restart();
    drive(1, 0, 0, 0, 0, 1, 0);
    step("restart");
    clear_hist();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end
  initial begin
    drive(1, 0, 0, 0, 0, 1, 0);
    tbl[0]  = '{1, 0, 0, 0, 0, 1, 0, ST_IDLE,          8'b0000_0000};
    tbl[1]  = '{0, 0, 0, 0, 1, 1, 0, ST_IDLE,          8'b0000_0000};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, ST_IDLE,          8'b0000_0000};
    tbl[3]  = '{0, 0, 1, 0, 0, 0, 0, ST_ESPERA_PUERTA, 8'b0000_0100};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, ST_ESPERA_PUERTA, 8'b0000_0100};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 1, ST_ESPERA_PUERTA, 8'b0000_0100};
    tbl[6]  = '{0, 0, 0, 0, 0, 1, 0, ST_LLENADO,       8'b1000_1100};
    tbl[7]  = '{0, 0, 0, 0, 0, 1, 1, ST_LAVADO,        8'b0100_1100};
    tbl[8]  = '{1, 0, 0, 0, 0, 1, 0, ST_IDLE,          8'b0000_0000};
    tbl[9]  = '{0, 1, 1, 0, 0, 1, 0, ST_ESPERA_PUERTA, 8'b0000_0100};
    tbl[10] = '{0, 0, 0, 0, 0, 1, 0, ST_LLENADO,       8'b1000_1100};
    tbl[11] = '{1, 0, 0, 0, 0, 1, 0, ST_IDLE,          8'b0000_0000};
    tbl[12] = '{0, 1, 1, 1, 0, 1, 0, ST_ESPERA_PUERTA, 8'b0000_0100};
    tbl[13] = '{0, 0, 0, 0, 0, 1, 0, ST_LLENADO,       8'b1000_1100};
    tbl[14] = '{0, 0, 0, 0, 0, 1, 1, ST_LAVADO,        8'b0101_1100};
    tbl[15] = '{1, 0, 0, 0, 0, 1, 0, ST_IDLE,          8'b0000_0000};
    tbl[16] = '{0, 1, 0, 0, 0, 1, 0, ST_ESPERA_PUERTA, 8'b0000_0100};
    tbl[17] = '{0, 0, 0, 0, 0, 1, 0, ST_SECADO,        8'b0101_1100};
    tbl[18] = '{1, 0, 0, 0, 0, 1, 0, ST_IDLE,          8'b0000_0000};
    clear_hist();
    foreach (tbl[k]) begin
      drive(tbl[k].r, tbl[k].s, tbl[k].l, tbl[k].p, tbl[k].i, tbl[k].d, tbl[k].n);
      step($sformatf("vec%0d", k));
      chk($sformatf("vec%0d table", k), {20'd0, bus.FASE, dut_o}, {20'd0, tbl[k].fase, tbl[k].outs});
    end
    // normal wash, water level reached on the second fill cycle
    restart();
    drive(0, 0, 1, 0, 0, 1, 0);
    step("s1 req");
    drive(0, 0, 0, 0, 0, 1, 0);
    step("s1 fill1");
    step("s1 fill2");
    drive(0, 0, 0, 0, 0, 1, 1);
    step("s1 lav");
    drive(0, 0, 0, 0, 0, 1, 0);
    run_until(ST_IDLE, 30, "s1");
    chk("s1 llenado cycles", hist[ST_LLENADO], 2);
    chk("s1 lavado cycles", hist[ST_LAVADO], TL);
    chk("s1 enjuague cycles", hist[ST_ENJUAGUE], TE);
    chk("s1 centrif cycles", hist[ST_CENTRIFUGADO], TC);
    chk("s1 secado cycles", hist[ST_SECADO], 0);
    chk("s1 fin pulses", fin_cnt, 1);
    // heavy wash: heater on through the long wash and the dry phase
    restart();
    drive(0, 0, 0, 1, 0, 1, 1);
    step("s2 req");
    drive(0, 0, 0, 0, 0, 1, 1);
    run_until(ST_IDLE, 40, "s2");
    chk("s2 heater cycles", cal_cnt, TLP + TS);
    chk("s2 lavado cycles", hist[ST_LAVADO], TLP);
    chk("s2 secado cycles", hist[ST_SECADO], TS);
    chk("s2 fin pulses", fin_cnt, 1);
    // simultaneous requests and a request pulse while busy
    restart();
    drive(0, 1, 1, 0, 0, 1, 1);
    step("s3 req");
    drive(0, 0, 0, 0, 0, 1, 1);
    run_until(ST_LAVADO, 5, "s3 lav");
    drive(0, 1, 0, 0, 0, 1, 1);
    step("s3 mid");
    drive(0, 0, 0, 0, 0, 1, 1);
    run_until(ST_IDLE, 40, "s3 end");
    chk("s3 secado cycles", hist[ST_SECADO], 0);
    chk("s3 lavado cycles", hist[ST_LAVADO], TL);
    chk("s3 fin pulses", fin_cnt, 1);
    // fill timeout
    restart();
    drive(0, 0, 1, 0, 0, 1, 0);
    step("s4 req");
    drive(0, 0, 0, 0, 0, 1, 0);
    run_until(ST_ERROR, 12, "s4");
    chk("s4 llenado cycles", hist[ST_LLENADO], TLM);
    chk("s4 valve off", {31'd0, bus.VALVULA_AGUA}, 0);
    drive(0, 0, 1, 0, 0, 1, 1);
    repeat (3) step("s4 hold");
    chk("s4 error held", {28'd0, bus.FASE}, {28'd0, ST_ERROR});
    drive(1, 0, 0, 0, 0, 1, 0);
    step("s4 reset");
    chk("s4 after reset", {20'd0, bus.FASE, dut_o}, 0);
    // door opened during spin
    restart();
    drive(0, 0, 1, 0, 0, 1, 1);
    step("s5 req");
    drive(0, 0, 0, 0, 0, 1, 1);
    run_until(ST_CENTRIFUGADO, 20, "s5 centrif");
    drive(0, 0, 0, 0, 0, 0, 1);
    step("s5 drop");
    chk("s5 error", {28'd0, bus.FASE}, {28'd0, ST_ERROR});
    chk("s5 spin off", {31'd0, bus.MOTOR_CENTRIF}, 0);
    // random traffic against the schedule model
    restart();
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 39) != 0,
            $urandom_range(0, 3) == 0);
      step("rand");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
